// File: rtl/jkff_bank_ctrl.sv
// jkff_bank_ctrl: command sequencer for a bank of WIDTH JK flip-flops.
// Accepts CLEAR / LOAD / COUNT / INVERT over a valid/ready handshake and
// drives the bank's J/K inputs for the required number of cycles. COUNT
// reads the bank's Q back to decode a synchronous binary up-count.
//
// Optional feature: define JKFF_CTRL_RST_CLEAR_EN to drive K=all ones
// while rst is high, so every reset edge clears the bank. Without it the
// J/K outputs are 0 under reset and the bank keeps its value.
module jkff_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CW-1:0]    cmd_count,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR  = 2'b00,
        OP_LOAD   = 2'b01,
        OP_COUNT  = 2'b10,
        OP_INVERT = 2'b11
    } op_t;

    state_t           state, state_n;
    logic [CW-1:0]    remaining, remaining_n;
    op_t              op_q, op_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             done_q, done_n;
    logic [WIDTH-1:0] count_mask;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == EXEC);
    assign done      = done_q;

    // State, step counter, captured command and done pulse register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so the update order inside this block is irrelevant.
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            op_q      <= OP_CLEAR;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            op_q      <= op_n;
            data_q    <= data_n;
            done_q    <= done_n;
        end
    end

    // Next-state logic: accept in IDLE, count down the active cycles in EXEC.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n     = state;
        remaining_n = remaining;
        op_n        = op_q;
        data_n      = data_q;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n   = op_t'(cmd_op);
                    data_n = cmd_data;
                    if (op_t'(cmd_op) == OP_COUNT) begin
                        if (cmd_count == '0) begin
                            // Zero-step COUNT completes immediately with no drive.
                            done_n = 1'b1;
                        end else begin
                            state_n     = EXEC;
                            remaining_n = cmd_count;
                        end
                    end else begin
                        state_n     = EXEC;
                        remaining_n = CW'(1);
                    end
                end
            end
            EXEC: begin
                if (remaining <= CW'(1)) begin
                    state_n     = IDLE;
                    remaining_n = '0;
                    done_n      = 1'b1;
                end else begin
                    remaining_n = remaining - CW'(1);
                end
            end
            default: begin
                state_n     = IDLE;
                remaining_n = '0;
            end
        endcase
    end

    // Count toggle mask: bit i toggles when all lower bank bits are 1.
    always_comb begin : count_decode
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            count_mask[i] = carry;
            carry         = carry & q_in[i];
        end
    end

    // J/K drive from state, captured command and live bank outputs.
    always_comb begin
        j_out = '0;
        k_out = '0;
        if (rst) begin
`ifdef JKFF_CTRL_RST_CLEAR_EN
            k_out = '1;
`else
            k_out = '0;
`endif
        end else if (state == EXEC) begin
            case (op_q)
                OP_CLEAR: begin
                    j_out = '0;
                    k_out = '1;
                end
                OP_LOAD: begin
                    j_out = data_q;
                    k_out = ~data_q;
                end
                OP_COUNT: begin
                    j_out = count_mask;
                    k_out = count_mask;
                end
                OP_INVERT: begin
                    j_out = '1;
                    k_out = '1;
                end
                default: begin
                    j_out = '0;
                    k_out = '0;
                end
            endcase
        end
    end

endmodule
